ram: RTL and testbench



---
 rtl/ram_pkg.sv | 17 +
 rtl/ram.sv | 49 ++++
 tb/tb_ram.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types for the core's data memory.
// The memory stage imports this package too, so widths and access codes stay in one place.
package ram_pkg;

    localparam int RAM_ADDR_W = 12;
    localparam int RAM_DATA_W = 32;

    typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
    typedef logic [RAM_DATA_W-1:0] ram_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2
    } ram_op_t;

endpackage : ram_pkg

// File: rtl/ram.sv
// Single-port synchronous data memory for the load/store path.
// Reads are registered, and dataOut holds between loads. clr clears the whole array asynchronously.
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              sel,
    input  logic              str,
    input  logic              ld,
    output logic [DATA_W-1:0] dataOut
);

    localparam int DEPTH = 2 ** ADDR_W;

    ram_word_t mem [DEPTH];
    ram_op_t   op;

    // A store takes priority over a load, and a colliding load is dropped.
    always_comb begin
        op = IDLE;
        if (sel && str) begin
            op = STORE;
        end else if (sel && ld) begin
            op = LOAD;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dataOut <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (op)
                STORE:   mem[address] <= dataIn;
                LOAD:    dataOut <= mem[address];
                default: ;
            endcase
        end
    end

endmodule : ram

// File: tb/tb_ram.sv
// Directed self-checking bench for the data memory.
// Expected values are hand-computed from the store/load sequence.
module tb_ram;

    logic        clk;
    logic        clr;
    logic [11:0] address;
    logic [31:0] dataIn;
    logic        sel;
    logic        str;
    logic        ld;
    logic [31:0] dataOut;

    int checkCount = 0;
    int errorCount = 0;

    ram #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk     (clk),
        .clr     (clr),
        .address (address),
        .dataIn  (dataIn),
        .sel     (sel),
        .str     (str),
        .ld      (ld),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic applyStimulus(input logic s, input logic w, input logic r,
                                 input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        sel     = s;
        str     = w;
        ld      = r;
        address = a;
        dataIn  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        clr     = 1'b0;
        sel     = 1'b1;
        str     = 1'b1;
        ld      = 1'b0;
        address = 12'h00A;
        dataIn  = 32'h0000_1234;

        #1;
        checkOutput("reset_t0", dataOut, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("reset_edge1", dataOut, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("reset_edge2", dataOut, 32'h0);

        @(negedge clk);
        clr = 1'b1;
        sel = 1'b0;
        str = 1'b0;

        applyStimulus(1, 0, 1, 12'h00A, 32'h0);
        checkOutput("post_reset_load", dataOut, 32'h0);

        applyStimulus(1, 1, 0, 12'h00A, 32'h0000_1234);
        checkOutput("store_no_out", dataOut, 32'h0);
        applyStimulus(1, 0, 1, 12'h00A, 32'h0);
        checkOutput("load_after_store", dataOut, 32'h0000_1234);
        applyStimulus(1, 0, 0, 12'h00A, 32'h0);
        checkOutput("hold_idle_sel", dataOut, 32'h0000_1234);
        applyStimulus(0, 0, 0, 12'h000, 32'h0);
        checkOutput("hold_deselect", dataOut, 32'h0000_1234);

        applyStimulus(0, 1, 0, 12'h00A, 32'hDEAD_BEEF);
        checkOutput("deselect_store_hold", dataOut, 32'h0000_1234);
        applyStimulus(0, 0, 1, 12'hFFF, 32'h0);
        checkOutput("deselect_load_hold", dataOut, 32'h0000_1234);
        applyStimulus(1, 0, 1, 12'h00A, 32'h0);
        checkOutput("deselect_store_dropped", dataOut, 32'h0000_1234);

        applyStimulus(1, 1, 1, 12'h00A, 32'hCAFE_0001);
        checkOutput("collision_hold", dataOut, 32'h0000_1234);
        applyStimulus(1, 0, 1, 12'h00A, 32'h0);
        checkOutput("collision_store_won", dataOut, 32'hCAFE_0001);

        applyStimulus(1, 1, 0, 12'h000, 32'hA5A5_A5A5);
        applyStimulus(1, 1, 0, 12'hFFF, 32'h5A5A_5A5A);
        checkOutput("boundary_store_hold", dataOut, 32'hCAFE_0001);
        applyStimulus(1, 0, 1, 12'h000, 32'h0);
        checkOutput("load_addr_000", dataOut, 32'hA5A5_A5A5);
        applyStimulus(1, 0, 1, 12'hFFF, 32'h0);
        checkOutput("load_addr_fff", dataOut, 32'h5A5A_5A5A);
        applyStimulus(1, 0, 1, 12'h00A, 32'h0);
        checkOutput("load_addr_00a_no_alias", dataOut, 32'hCAFE_0001);
        applyStimulus(1, 0, 1, 12'h800, 32'h0);
        checkOutput("load_addr_800_no_alias", dataOut, 32'h0);
        applyStimulus(1, 0, 1, 12'h7FF, 32'h0);
        checkOutput("load_addr_7ff_no_alias", dataOut, 32'h0);
        applyStimulus(1, 0, 1, 12'hFFF, 32'h0);
        checkOutput("reload_addr_fff", dataOut, 32'h5A5A_5A5A);

        // Clear pulse lands between edges; the output must drop before any clock edge.
        @(negedge clk);
        sel = 1'b0;
        ld  = 1'b0;
        #1;
        clr = 1'b0;
        #1;
        checkOutput("midcycle_reset_out", dataOut, 32'h0);
        #1;
        clr = 1'b1;

        applyStimulus(1, 0, 1, 12'h00A, 32'h0);
        checkOutput("cleared_addr_00a", dataOut, 32'h0);
        applyStimulus(1, 0, 1, 12'hFFF, 32'h0);
        checkOutput("cleared_addr_fff", dataOut, 32'h0);
        applyStimulus(1, 0, 1, 12'h000, 32'h0);
        checkOutput("cleared_addr_000", dataOut, 32'h0);

        applyStimulus(1, 1, 0, 12'h123, 32'h1357_9BDF);
        applyStimulus(1, 0, 1, 12'h123, 32'h0);
        checkOutput("store_load_after_clear", dataOut, 32'h1357_9BDF);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule : tb_ram
